// File: rtl/cordic_prerotate_nco.sv
// CORDIC rotator front end: NCO phase accumulator with a double-buffered tuning word,
// followed by a conditional 180-degree pre-rotation that folds the phase into +/-90 degrees.
module cordic_prerotate_nco #(
  parameter int IW = 14,
  parameter int WW = 16,
  parameter int PW = 20
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  input  logic          i_ce,
  input  logic          i_sync,
  input  logic          i_ftw_load,
  input  logic [PW-1:0] i_ftw,
  input  logic [PW-1:0] i_phase_ofs,
  input  logic [IW-1:0] i_x,
  input  logic [IW-1:0] i_y,
  output logic [WW-1:0] o_x,
  output logic [WW-1:0] o_y,
  output logic [PW-1:0] o_phase,
  output logic          o_valid,
  output logic          o_ftw_ack
);

  // Negating the most negative input must not wrap, and stage 0 onwards needs CORDIC gain room.
  if (WW < IW + 2) begin : g_width_check
    $error("cordic_prerotate_nco: WW must be at least IW+2");
  end

  logic [PW-1:0] acc_q, acc_d;
  logic [PW-1:0] ftw_active_q, ftw_pend_q;
  logic          pend_q;
  logic [PW-1:0] pa_q, pa_d;
  logic [WW-1:0] xa_q, ya_q;
  logic          primed_q;
  logic [WW-1:0] x_q, y_q, x_d, y_d;
  logic [PW-1:0] phase_q, phase_d;
  logic          valid_q, ack_q;
  logic          fold;

  // NOTE: every always_comb output gets a default up front so no path can infer a latch.
  always_comb begin
    acc_d   = acc_q + ftw_active_q;
    pa_d    = acc_q + i_phase_ofs;
    if (i_sync) begin
      acc_d = '0;
      pa_d  = i_phase_ofs;
    end
    // Quadrants 01 and 10 lie outside +/-90 degrees; rotate them by 180 degrees.
    fold    = pa_q[PW-1] ^ pa_q[PW-2];
    x_d     = fold ? -xa_q : xa_q;
    y_d     = fold ? -ya_q : ya_q;
    phase_d = {pa_q[PW-1] ^ fold, pa_q[PW-2:0]};
  end

  // Tuning word handshake runs on every clock; only the apply waits for i_ce.
  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      ftw_active_q <= '0;
      ftw_pend_q   <= '0;
      pend_q       <= 1'b0;
      ack_q        <= 1'b0;
    end else begin
      ack_q <= i_ce & pend_q;
      if (i_ce && pend_q) ftw_active_q <= ftw_pend_q;
      if (i_ftw_load) begin
        ftw_pend_q <= i_ftw;
        pend_q     <= 1'b1;
      end else if (i_ce) begin
        pend_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      acc_q    <= '0;
      pa_q     <= '0;
      xa_q     <= '0;
      ya_q     <= '0;
      x_q      <= '0;
      y_q      <= '0;
      phase_q  <= '0;
      primed_q <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      valid_q <= i_ce & primed_q;
      if (i_ce) begin
        primed_q <= 1'b1;
        acc_q    <= acc_d;
        pa_q     <= pa_d;
        xa_q     <= {{(WW-IW){i_x[IW-1]}}, i_x};
        ya_q     <= {{(WW-IW){i_y[IW-1]}}, i_y};
        x_q      <= x_d;
        y_q      <= y_d;
        phase_q  <= phase_d;
      end
    end
  end

  assign o_x       = x_q;
  assign o_y       = y_q;
  assign o_phase   = phase_q;
  assign o_valid   = valid_q;
  assign o_ftw_ack = ack_q;

endmodule

// File: tb/tb_cordic_prerotate_nco.sv
// Directed bench for cordic_prerotate_nco: priming, fold boundaries, extremes,
// tuning-word handshake, phase wrap, sync and asynchronous reset.
module tb_cordic_prerotate_nco;

  localparam int IW = 14;
  localparam int WW = 16;
  localparam int PW = 20;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ce = 1'b0, sync = 1'b0, ftw_load = 1'b0;
  logic [PW-1:0] ftw = '0, ofs = '0;
  logic [IW-1:0] x = '0, y = '0;
  logic [WW-1:0] o_x, o_y;
  logic [PW-1:0] o_phase;
  logic          o_valid, o_ftw_ack;

  int passed = 0;
  int total  = 0;

  cordic_prerotate_nco #(.IW(IW), .WW(WW), .PW(PW)) dut (
    .i_clk      (clk),
    .i_reset_n  (rst_n),
    .i_ce       (ce),
    .i_sync     (sync),
    .i_ftw_load (ftw_load),
    .i_ftw      (ftw),
    .i_phase_ofs(ofs),
    .i_x        (x),
    .i_y        (y),
    .o_x        (o_x),
    .o_y        (o_y),
    .o_phase    (o_phase),
    .o_valid    (o_valid),
    .o_ftw_ack  (o_ftw_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state and priming
    x = 14'd100;
    #12;
    check("rst_x", o_x, 0);
    check("rst_phase", o_phase, 0);
    check("rst_valid", o_valid, 0);
    rst_n = 1'b1;
    ce = 1'b1;
    tick();
    check("prime1_x", o_x, 0);
    check("prime1_valid", o_valid, 0);
    tick();
    check("prime2_x", $signed(o_x), 100);
    check("prime2_phase", o_phase, 0);
    check("prime2_valid", o_valid, 1);
    tick();
    check("prime3_valid", o_valid, 1);

    // Fold boundaries
    x = 14'(1000); y = 14'(-500); ofs = 20'h3FFFF;
    tick(); tick();
    check("b3ffff_phase", o_phase, 20'h3FFFF);
    check("b3ffff_x", $signed(o_x), 1000);
    check("b3ffff_y", $signed(o_y), -500);
    ofs = 20'h40000;
    tick(); tick();
    check("b40000_phase", o_phase, 20'hC0000);
    check("b40000_x", $signed(o_x), -1000);
    check("b40000_y", $signed(o_y), 500);
    ofs = 20'hC0000;
    tick(); tick();
    check("bc0000_phase", o_phase, 20'hC0000);
    check("bc0000_x", $signed(o_x), 1000);
    check("bc0000_y", $signed(o_y), -500);

    // Extremes: most negative input negated without wrap
    x = 14'(-8192); y = 14'(8191); ofs = 20'h80000;
    tick(); tick();
    check("ext_phase", o_phase, 20'h00000);
    check("ext_x", $signed(o_x), 8192);
    check("ext_y", $signed(o_y), -8191);

    // Hold with i_ce low
    ce = 1'b0; x = 14'd5; ofs = 20'h12345;
    tick(); tick();
    check("hold_x", $signed(o_x), 8192);
    check("hold_phase", o_phase, 20'h00000);
    check("hold_valid", o_valid, 0);

    // Tuning word load while i_ce low, applied at next i_ce edge
    ofs = '0; x = 14'd0; y = 14'd0;
    ftw_load = 1'b1; ftw = 20'h10000;
    tick();
    ftw_load = 1'b0;
    check("ld_noack", o_ftw_ack, 0);
    ce = 1'b1;
    tick();
    check("ld_ack", o_ftw_ack, 1);
    tick();
    check("ld_ack_clear", o_ftw_ack, 0);
    check("ld_pa0", o_phase, 20'h00000);
    tick();
    check("ld_pa1", o_phase, 20'h00000);
    tick();
    check("ld_pa2", o_phase, 20'h10000);
    tick();
    check("ld_pa3", o_phase, 20'h20000);

    // Two loads before an i_ce edge: latest wins, single ack; apply coincides with sync
    ce = 1'b0;
    ftw_load = 1'b1; ftw = 20'h11111;
    tick();
    ftw = 20'hC0000;
    tick();
    ftw_load = 1'b0;
    x = 14'(1000); y = 14'(-500);
    ce = 1'b1; sync = 1'b1;
    tick();
    sync = 1'b0;
    check("dbl_ack", o_ftw_ack, 1);
    tick();
    check("dbl_ack_once", o_ftw_ack, 0);
    check("wrap_s0", o_phase, 20'h00000);
    tick();
    check("wrap_s1", o_phase, 20'h00000);
    check("dbl_no_second_ack", o_ftw_ack, 0);
    tick();
    check("wrap_s2", o_phase, 20'hC0000);
    tick();
    check("wrap_s3", o_phase, 20'h00000);
    check("wrap_s3_x", $signed(o_x), -1000);
    tick();
    check("wrap_s4", o_phase, 20'hC0000);

    // Sync mid-stream: pa restarts at offset, valid stays high
    ofs = 20'h12345; sync = 1'b1;
    tick();
    sync = 1'b0;
    check("sync_valid0", o_valid, 1);
    tick();
    check("sync_pa", o_phase, 20'h12345);
    check("sync_valid1", o_valid, 1);
    tick();
    check("sync_pa1", o_phase, 20'h12345);
    tick();
    check("sync_pa2", o_phase, 20'hD2345);

    // Asynchronous reset with a tuning word pending
    ce = 1'b0;
    ftw_load = 1'b1; ftw = 20'h00001;
    tick();
    ftw_load = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_x", o_x, 0);
    check("arst_y", o_y, 0);
    check("arst_phase", o_phase, 0);
    check("arst_valid", o_valid, 0);
    check("arst_ack", o_ftw_ack, 0);
    rst_n = 1'b1;
    ce = 1'b1;
    tick();
    check("arst_noack0", o_ftw_ack, 0);
    tick();
    check("arst_noack1", o_ftw_ack, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/cordic_prerotate_nco.md
# cordic_prerotate_nco

Front end of the CORDIC rotator. It generates the rotation phase with an NCO phase accumulator (tuning word plus offset) and registers the input vector alongside it. It then folds the phase into ±90° by a conditional 180° pre-rotation, so the phase entering the first CORDIC micro-rotation stage lies inside the convergence range. Its outputs drive the x/y/phase inputs of CORDIC stage 0 directly, on the same clock and clock enable.

## Interface
- IW, 14: input vector width, signed.
- WW, 16: working width of output x/y, signed. Must satisfy WW ≥ IW+2; elaboration fails otherwise.
- PW, 20: phase width, unsigned two's-complement turns (2^PW = 360°).
- i_clk  in  1  clock, rising edge.
- i_reset_n  in  1  reset, asynchronous, active-low.
- i_ce  in  1  clock enable; the pipeline advances only on edges where i_ce=1.
- i_sync  in  1  phase reset, sampled only when i_ce=1.
- i_ftw_load  in  1  one-cycle strobe that captures i_ftw.
- i_ftw  in  PW  frequency tuning word.
- i_phase_ofs  in  PW  static phase offset, sampled on i_ce.
- i_x, i_y  in  IW  signed input vector.
- o_x, o_y  out  WW  signed pre-rotated vector, to stage 0.
- o_phase  out  PW  folded residual phase, to stage 0.
- o_valid  out  1  one-cycle strobe marking a new output sample.
- o_ftw_ack  out  1  one-cycle pulse when a loaded tuning word becomes active.

## Operation
- Internal state: acc[PW], ftw_active[PW], ftw_pend[PW], pend flag, stage-A registers (xa, ya, pa), primed flag.
- Tuning word handshake:
  - i_ftw_load=1 captures i_ftw into ftw_pend and sets pend. This happens regardless of i_ce.
  - If a second load arrives while pend=1, it overwrites ftw_pend. Latest wins; only one ack is issued.
  - On an i_ce edge with pend=1, ftw_pend is copied into ftw_active and pend clears. o_ftw_ack pulses on the next cycle.
  - The accumulator update on that same edge still uses the old ftw_active.
  - If i_ftw_load and an apply coincide, the apply moves the old ftw_pend. The new word stays pending and is applied at the next i_ce edge with its own ack.
- Stage A (on i_ce):
  - If i_sync=1: acc ← 0 and pa ← i_phase_ofs.
  - Otherwise: acc ← acc + ftw_active (mod 2^PW) and pa ← acc + i_phase_ofs (mod 2^PW), using acc before the update.
  - In both cases xa ← sign-extend(i_x) to WW and ya ← sign-extend(i_y) to WW.
- Stage B (on i_ce), quadrant fold on pa[PW-1:PW-2]:
  - 00 or 11 (within ±90°): o_x ← xa, o_y ← ya, o_phase ← pa.
  - 01 or 10: o_x ← −xa, o_y ← −ya, o_phase ← pa with the MSB inverted (subtract 180°).
  - Negation is done in WW bits. The WW ≥ IW+2 headroom guarantees no overflow and leaves room for the CORDIC gain.
- Valid tracking:
  - primed is set on the first i_ce edge after reset and stays set. i_sync does not clear it.
  - o_valid ← i_ce & primed, registered. o_valid is 0 on cycles with no i_ce edge.
- Reset (i_reset_n=0, asynchronous): every register and output goes to 0, i.e. o_x, o_y, o_phase, o_valid, o_ftw_ack, acc, ftw_active, ftw_pend, pend, primed.
  - Asserting reset mid-operation drops a pending tuning word without an ack.

## Timing
- Latency is 2 i_ce edges. A vector sampled at i_ce edge n appears on o_x/o_y at edge n+1. o_valid is high in the cycle after edge n+1.
- Phase paired with that vector: pa = acc(before edge n) + i_phase_ofs(edge n), folded at edge n+1.
- With i_ce held low, all outputs hold their values. o_valid and o_ftw_ack stay 0.
- o_ftw_ack is high exactly one cycle, following the applying i_ce edge.
- There is no combinational path from any input to any output.

## Test plan
- Reset and prime: release reset, then hold i_ce=1 with i_x=100, i_y=0, ftw=0, offset=0.
  - Outputs stay 0 until the second edge.
  - After that, o_x=100 and o_phase=0.
  - o_valid is high from the cycle after the second edge onward.
- Fold boundary, with PW=20 and i_x=1000, i_y=−500:
  - Offset 0x3FFFF → o_phase=0x3FFFF, o_x=1000, o_y=−500.
  - Offset 0x40000 → o_phase=0xC0000, o_x=−1000, o_y=500.
  - Offset 0xC0000 → passes through unchanged.
- Extremes: i_x=−8192 (IW=14, 0x80000 offset) → o_x=+8192 with no wrap.
- Tuning word handshake:
  - Load 0x10000 → ack one cycle after the next i_ce edge.
  - The pa sequence then steps 0x10000 per i_ce, starting one edge after the apply.
  - Two loads before any i_ce → one ack, and the second value is used.
- Wrap and sync:
  - ftw=0xC0000 → pa wraps mod 2^20 (0, 0xC0000, 0x80000, …).
  - i_sync=1 on an i_ce edge → pa=offset and acc restarts from 0.
  - o_valid stays asserted across the sync.
- Reset mid-operation: assert i_reset_n=0 asynchronously between edges while pend=1.
  - All outputs go to 0 immediately.
  - No ack follows after reset is released.
